riscv_mem_timer: RTL



---
 rtl/riscv_mem_timer_if.sv | 22 ++
 rtl/riscv_mem_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_timer_if.sv
// Data-port bus between the VProc wrapper master and the RAM/timer slave.
// Carries the read/write handshake, read data and the timer interrupt.
interface riscv_mem_timer_if;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        irq;

  modport master (
    output address, write, writedata, byteenable, read,
    input  readdata, waitrequest, irq
  );

  modport slave (
    input  address, write, writedata, byteenable, read,
    output readdata, waitrequest, irq
  );
endinterface

// File: rtl/riscv_mem_timer.sv
// Word RAM with programmable read wait states plus a 64-bit mtime/mtimecmp
// timer raising a level interrupt. Writes complete in their own cycle.
module riscv_mem_timer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_WAIT    = 2,
  parameter logic [31:0] TIMER_BASE = 32'hAFFF_FFE0,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_mem_timer_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PS_W  = 16;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  // Address decode
  logic                  bus_hit;
  logic [2:0]            bus_off;
  logic [ADDR_WIDTH-1:0] bus_idx;
  logic                  ram_we;
  logic                  tmr_we;
  logic                  unused_addr_bits;

  assign bus_hit          = (bus.address[31:5] == TIMER_BASE[31:5]);
  assign bus_off          = bus.address[4:2];
  assign bus_idx          = bus.address[ADDR_WIDTH+1:2];
  assign ram_we           = bus.write & ~bus_hit;
  assign tmr_we           = bus.write & bus_hit;
  assign unused_addr_bits = ^bus.address[1:0];

  // Timer state
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            en_q, en_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;
  logic            irq_q;

  // Prescaler, mtime increment and register writes; written bytes win over the increment
  always_comb begin
    tick       = 1'b0;
    ps_d       = '0;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    if (en_q) begin
      if (ps_q == PS_W'(PRESCALE - 1)) begin
        tick = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
    mtime_d = mtime_q + 64'(tick);
    if (tmr_we) begin
      case (bus_off)
        3'd0: mtime_d[31:0]     = merge_bytes(mtime_d[31:0], bus.writedata, bus.byteenable);
        3'd1: mtime_d[63:32]    = merge_bytes(mtime_d[63:32], bus.writedata, bus.byteenable);
        3'd2: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus.writedata, bus.byteenable);
        3'd3: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.writedata, bus.byteenable);
        3'd4: if (bus.byteenable[0]) en_d = bus.writedata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      ps_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      ps_q       <= ps_d;
      irq_q      <= en_q & (mtime_q >= mtimecmp_q);
    end
  end

  // RAM storage; contents are not reset
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem[bus_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  // Read FSM
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cap_hit_q, cap_hit_d;
  logic [2:0]            cap_off_q, cap_off_d;
  logic [ADDR_WIDTH-1:0] cap_idx_q, cap_idx_d;
  logic                  rd_load;
  logic                  waitreq_c;
  logic                  rd_hit;
  logic [2:0]            rd_off;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           ram_word;
  logic [31:0]           rd_word;
  logic [31:0]           rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_hit_d = cap_hit_q;
    cap_off_d = cap_off_q;
    cap_idx_d = cap_idx_q;
    rd_load   = 1'b0;
    waitreq_c = 1'b0;
    rd_hit    = cap_hit_q;
    rd_off    = cap_off_q;
    rd_idx    = cap_idx_q;
    case (state_q)
      IDLE: begin
        waitreq_c = bus.read;
        rd_hit    = bus_hit;
        rd_off    = bus_off;
        rd_idx    = bus_idx;
        if (bus.read) begin
          cap_hit_d = bus_hit;
          cap_off_d = bus_off;
          cap_idx_d = bus_idx;
          if (RD_WAIT <= 1) begin
            rd_load = 1'b1;
            state_d = ACK;
          end else begin
            cnt_d   = CNT_W'(RD_WAIT - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        waitreq_c = 1'b1;
        if (!bus.read) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          rd_load = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux sees post-write values so a read sharing a write cycle returns new data
  always_comb begin
    ram_word = mem[rd_idx];
    if (ram_we && (bus_idx == rd_idx)) begin
      ram_word = merge_bytes(ram_word, bus.writedata, bus.byteenable);
    end
    rd_word = '0;
    if (rd_hit) begin
      case (rd_off)
        3'd0:    rd_word = mtime_d[31:0];
        3'd1:    rd_word = mtime_d[63:32];
        3'd2:    rd_word = mtimecmp_d[31:0];
        3'd3:    rd_word = mtimecmp_d[63:32];
        3'd4:    rd_word = {31'd0, en_d};
        default: rd_word = '0;
      endcase
    end else begin
      rd_word = ram_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_hit_q <= 1'b0;
      cap_off_q <= '0;
      cap_idx_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_hit_q <= cap_hit_d;
      cap_off_q <= cap_off_d;
      cap_idx_q <= cap_idx_d;
      if (rd_load) rdata_q <= rd_word;
    end
  end

  assign bus.readdata    = rdata_q;
  assign bus.waitrequest = waitreq_c;
  assign bus.irq         = irq_q;

endmodule
